// File: rtl/vx_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : vx_decode_queue
// Purpose  : Decoded-instruction FIFO with per-warp occupancy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module vx_decode_queue #(
  parameter int DATAW     = 64,
  parameter int DEPTH     = 4,
  parameter int NUM_WARPS = 4,
  localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [NW_BITS-1:0] wid_in,
  input  logic [DATAW-1:0]   data_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [NW_BITS-1:0] wid_out,
  output logic [DATAW-1:0]   data_out,
  input  logic               ready_out,
  output logic [CNT_W-1:0]   count,
  output logic [NUM_WARPS-1:0] pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

  logic [DATAW-1:0]   r_data [DEPTH];
  logic [NW_BITS-1:0] r_wid  [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign ready_in  = (r_count != c_FULL) && !flush;
  assign valid_out = (r_count != '0);
  assign w_push    = valid_in && ready_in;
  // A pop offered during flush is discarded along with everything else.
  assign w_pop     = valid_out && ready_out && !flush;

  assign wid_out  = r_wid[r_rd_ptr];
  assign data_out = r_data[r_rd_ptr];
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= data_in;
      r_wid[r_wr_ptr]  <= wid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc = w_push && (wid_in == NW_BITS'(g));
    assign w_dec = w_pop && (wid_out == NW_BITS'(g));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_inc && w_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign pending_mask[g] = (r_cnt != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_decode_queue
// Purpose  : Scoreboard bench for vx_decode_queue with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_decode_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NW    = 4;
  localparam int NWB   = 2;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [NWB-1:0] wid_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          ready_in;
  logic          valid_out;
  logic [NWB-1:0] wid_out;
  logic [DW-1:0] data_out;
  logic          ready_out = 1'b0;
  logic [CW-1:0] count;
  logic [NW-1:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NWB+DW-1:0] exp_q[$];

  vx_decode_queue #(.DATAW(DW), .DEPTH(DEPTH), .NUM_WARPS(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .wid_in(wid_in), .data_in(data_in), .ready_in(ready_in),
    .valid_out(valid_out), .wid_out(wid_out), .data_out(data_out), .ready_out(ready_out),
    .count(count), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NW-1:0] model_mask();
    logic [NW-1:0] m = '0;
    foreach (exp_q[i]) m[exp_q[i][DW +: NWB]] = 1'b1;
    return m;
  endfunction

  task automatic check_state();
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("valid_out", 64'(valid_out), 64'(exp_q.size() != 0));
    chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
  endtask

  // One clock cycle: check registered state, drive inputs, update the model.
  task automatic step(input logic vi, input logic [NWB-1:0] w, input logic [DW-1:0] d,
                      input logic ro, input logic fl);
    logic exp_rdy;
    @(negedge clk);
    check_state();
    valid_in = vi; wid_in = w; data_in = d; ready_out = ro; flush = fl;
    #1;
    exp_rdy = (exp_q.size() != DEPTH) && !fl;
    chk("ready_in", 64'(ready_in), 64'(exp_rdy));
    if (fl) exp_q.delete();
    else if (vi && exp_rdy) exp_q.push_back({w, d});
  endtask

  task automatic async_reset();
    @(negedge clk);
    check_state();
    valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd1);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Pops happen just before the rising edge, after the stimulus has settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && valid_out && ready_out && !flush) begin
        if (exp_q.size() == 0) begin
          chk("pop_on_empty_model", 64'd1, 64'd0);
        end else begin
          chk("data_out", 64'(data_out), 64'(exp_q[0][DW-1:0]));
          chk("wid_out", 64'(wid_out), 64'(exp_q[0][DW +: NWB]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    #3;
    chk("init_count", 64'(count), 64'd0);
    chk("init_valid_out", 64'(valid_out), 64'd0);
    chk("init_pending", 64'(pending_mask), 64'd0);
    chk("init_ready_in", 64'(ready_in), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Fill then drain
    for (int i = 0; i < 4; i++) step(1'b1, NWB'(i), DW'(32'hA0 + i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("fill_mask", 64'(pending_mask), 64'hF);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("drain_count", 64'(count), 64'd0);

    // Push/pop at full: first push refused, second accepted
    for (int i = 0; i < 4; i++) step(1'b1, NWB'(i), DW'(32'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'hB0, 1'b1, 1'b0);
    step(1'b1, 2'd1, 32'hB1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Same-warp push/pop
    step(1'b1, 2'd2, 32'h22, 1'b0, 1'b0);
    step(1'b1, 2'd2, 32'h23, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("same_warp_mask", 64'(pending_mask), 64'b0100);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Wrap-around at steady count 2
    step(1'b1, 2'd3, 32'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'd1, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) step(1'b1, NWB'(i), DW'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with push and pop offered
    for (int i = 0; i < 3; i++) step(1'b1, NWB'(i), DW'(32'hD0 + i), 1'b0, 1'b0);
    step(1'b1, 2'd3, 32'hDD, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset with entries stored
    for (int i = 0; i < 3; i++) step(1'b1, NWB'(i), DW'(32'hE0 + i), 1'b0, 1'b0);
    async_reset();
    step(1'b1, 2'd1, 32'hF1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("post_reset_count", 64'(count), 64'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), NWB'($urandom_range(0, NW - 1)), DW'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end

    // Bounded drain
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++)
      step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_decode_queue.md
VX_DECODE_QUEUE -- requirements
Module: VX_decode_queue

Interface
REQ-001 Parameter DATAW, default 64: payload width in bits (uuid, tmask, PC, ex/op fields, imm, register indices packed by the producer).
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-003 Parameter NUM_WARPS, default 4: warp count; NW_BITS = max(1, clog2(NUM_WARPS)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all stored entries.
REQ-007 valid_in  input  1  producer offers an entry.
REQ-008 wid_in  input  NW_BITS  warp id of the offered entry.
REQ-009 data_in  input  DATAW  payload of the offered entry.
REQ-010 ready_in  output  1  queue accepts an entry this cycle.
REQ-011 valid_out  output  1  head entry available.
REQ-012 wid_out  output  NW_BITS  warp id of the head entry.
REQ-013 data_out  output  DATAW  payload of the head entry.
REQ-014 ready_out  input  1  consumer takes the head entry this cycle.
REQ-015 count  output  clog2(DEPTH+1)  number of stored entries.
REQ-016 pending_mask  output  NUM_WARPS  bit w set while any stored entry has wid w.

Function
REQ-017 Push = valid_in & ready_in; pop = valid_out & ready_out; both evaluated in the same cycle.
REQ-018 ready_in = (count != DEPTH) & ~flush; no combinational dependence on ready_out.
REQ-019 valid_out = (count != 0); wid_out/data_out driven from the head slot; no empty bypass.
REQ-020 Latency: entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
REQ-021 Order: strict FIFO across all warps.
REQ-022 Write and read pointers are clog2(DEPTH) bits; each increments by one on push or pop and wraps from DEPTH-1 to 0.
REQ-023 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 Full (count == DEPTH): ready_in = 0 even if a pop occurs that cycle; a pop still proceeds.
REQ-025 Empty (count == 0): valid_out = 0; a push proceeds; outputs other than valid_out are don't-care.
REQ-026 Per-warp counter cnt[w], width clog2(DEPTH+1): +1 on push with wid_in = w, -1 on pop with wid_out = w, unchanged when both match the same w.
REQ-027 pending_mask[w] = (cnt[w] != 0), registered-state derived, no dependence on same-cycle push or pop.
REQ-028 Flush: next cycle count = 0, pointers = 0, all cnt[w] = 0, pending_mask = 0; a pop presented in the flush cycle is a no-op; valid_out is not gated by flush in that cycle.
REQ-029 Flush has priority over push and pop; flush while empty is a no-op with the same end state.
REQ-030 Invariant: sum over w of cnt[w] == count at every cycle.

Reset
REQ-031 Reset asserted: immediately, without a clock edge, count = 0, pointers = 0, all cnt[w] = 0, valid_out = 0, pending_mask = 0, ready_in = 1 (gated by flush).
REQ-032 Storage array contents are not reset; data_out/wid_out are don't-care while valid_out = 0.
REQ-033 Reset asserted mid-operation discards all entries; the first push after deassertion becomes head with count = 1.

Verification
REQ-034 Fill/drain, DEPTH=4: push wid 0,1,2,3 with data 0xA0..0xA3, ready_out = 0 -> count = 4, ready_in = 0, pending_mask = 4'b1111; then ready_out = 1 -> outputs 0xA0..0xA3 in order on 4 consecutive cycles, count = 0, pending_mask = 0.
REQ-035 Simultaneous push/pop at full: count = 4, valid_in = 1, ready_out = 1 -> pop occurs, push refused, count = 3; next cycle push accepted, count stays 3.
REQ-036 Same-warp push/pop: one entry wid 2 stored, push wid 2 while popping -> cnt[2] = 1, pending_mask[2] = 1, count = 1.
REQ-037 Wrap-around: 10 push/pop pairs with data 0..9 at steady count 2 -> data_out sequence 0..9 with no loss or duplication, pointers wrap twice.
REQ-038 Flush: 3 entries stored, flush = 1 with valid_in = 1 and ready_out = 1 -> ready_in = 0 that cycle; next cycle count = 0, valid_out = 0, pending_mask = 0.
REQ-039 Async reset: reset pulsed between clock edges with count = 3 -> valid_out = 0 and count = 0 before the next rising edge; a push after deassertion yields count = 1.
